uart_tx_stream: RTL and testbench

Parametrised UART transmitter. It accepts arbitrary bytes over a valid/ready stream interface, buffers them in a small FIFO, and serialises them onto a single tx line. Frame format (data bits, parity, stop bits) and bit period are set by parameters. It replaces fixed-message transmitters: any upstream block (console, debug dump, CPU I/O port) can push characters without knowing UART timing.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_fifo.sv | 63 ++++++
 rtl/uart_tx_stream.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_stream.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes and the transmit/receive FSM
// state encoding, plus a small parity helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Turns the XOR of the data bits into the transmitted parity bit.
  function automatic logic parity_bit(input logic data_xor, input int parity_mode);
    return (parity_mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO: pop_data presents the oldest entry whenever
// the FIFO is not empty. Pointers wrap naturally since DEPTH is a power of 2.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;

  // Storage write; contents are left alone on reset, the pointers discard them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// Stream-fed UART transmitter. Bytes arrive over valid/ready into a small
// FIFO and are serialised LSB first with optional parity and 1 or 2 stop
// bits. tx is a registered copy of the current state's line level, so the
// pin lags the FSM by one cycle and is glitch free.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 12000000 / 9600,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int PARITY         = 0,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  uart_state_t          state_reg;
  uart_state_t          state_next;
  logic [BAUD_W-1:0]    baud_cnt_reg;
  logic [BIT_W-1:0]     bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_data_reg;
  logic                 parity_reg;
  logic                 tx_reg;
  logic                 tx_next;
  logic                 active_reg;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_data;
  logic [CNT_W-1:0]     fifo_count_w;
  logic                 fifo_full;
  logic                 fifo_empty;

  logic                 bit_done;
  logic                 last_data_bit;
  logic                 last_stop_bit;

  assign data_ready    = ~rst & ~fifo_full;
  assign fifo_push     = data_valid & data_ready;
  assign bit_done      = (baud_cnt_reg == BAUD_W'(CLOCKS_PER_BIT - 1));
  assign last_data_bit = (bit_cnt_reg == BIT_W'(DATA_BITS - 1));
  assign last_stop_bit = (bit_cnt_reg == BIT_W'(STOP_BITS - 1));

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .count     (fifo_count_w),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: each bit lasts one full baud period; stop chains
  // straight into the next start when another byte is waiting.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_START;
      end
      ST_START: begin
        if (bit_done) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done && last_data_bit) begin
          state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_done) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (bit_done && last_stop_bit) begin
          state_next = fifo_empty ? ST_IDLE : ST_START;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: line level for the current state and the FIFO pop strobe.
  always_comb begin
    tx_next  = 1'b1;
    fifo_pop = 1'b0;
    case (state_reg)
      ST_IDLE:   fifo_pop = ~fifo_empty;
      ST_START:  tx_next  = 1'b0;
      ST_DATA:   tx_next  = shift_data_reg[0];
      ST_PARITY: tx_next  = parity_reg;
      ST_STOP:   fifo_pop = bit_done & last_stop_bit & ~fifo_empty;
      default:   tx_next  = 1'b1;
    endcase
  end

  // Datapath: baud/bit counters restart on every state entry, the shifter
  // and parity load on pop, and the line flop follows the state's level.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      shift_data_reg <= '0;
      parity_reg     <= 1'b0;
      tx_reg         <= 1'b1;
      active_reg     <= 1'b0;
    end else begin
      tx_reg     <= tx_next;
      active_reg <= (state_reg != ST_IDLE);

      if (state_next != state_reg || bit_done) begin
        baud_cnt_reg <= '0;
      end else begin
        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
      end

      if (state_next != state_reg) begin
        bit_cnt_reg <= '0;
      end else if (bit_done) begin
        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
      end

      if (fifo_pop) begin
        shift_data_reg <= fifo_data;
        parity_reg     <= parity_bit(^fifo_data, PARITY);
      end else if (state_reg == ST_DATA && bit_done) begin
        shift_data_reg <= {1'b0, shift_data_reg[DATA_BITS-1:1]};
      end
    end
  end

  assign tx         = tx_reg;
  assign fifo_count = fifo_count_w;
  // active_reg keeps busy high while the last stop bit is still on the pin,
  // one cycle after the FSM has already returned to IDLE.
  assign busy       = (state_reg != ST_IDLE) | active_reg | (fifo_count_w != '0);

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: four instances with different frame formats
// share clock and reset. A line-level model predicts tx, busy, data_ready
// and fifo_count each cycle; directed pushes add literal spot checks.
module tb_uart_tx_stream;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int NI    = 4;
  localparam int RING  = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       valid_v [NI];
  logic [7:0] data_v  [NI];
  logic       tx_w    [NI];
  logic       busy_w  [NI];
  logic       ready_w [NI];
  logic [2:0] cnt_w   [NI];

  // Instance 0: 8N1, 1: 8 data even parity, 2: 8 data odd parity, 3: 7N2.
  function automatic int cfg_db(input int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int cfg_sb(input int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int cfg_par(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int DB  = (gi == 3) ? 7 : 8;
      localparam int SB  = (gi == 3) ? 2 : 1;
      localparam int PAR = (gi == 1) ? 2 : ((gi == 2) ? 1 : 0);
      uart_tx_stream #(
        .CLOCKS_PER_BIT (CPB),
        .DATA_BITS      (DB),
        .STOP_BITS      (SB),
        .PARITY         (PAR),
        .FIFO_DEPTH     (DEPTH)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data_v[gi][DB-1:0]),
        .data_valid (valid_v[gi]),
        .data_ready (ready_w[gi]),
        .tx         (tx_w[gi]),
        .busy       (busy_w[gi]),
        .fifo_count (cnt_w[gi])
      );
    end
  endgenerate

  int checks   = 0;
  int failures = 0;

  // Model state: a per-instance list of future line levels (one per cycle),
  // each flagged if the byte queue is popped on that edge.
  bit lvl_r [NI][RING];
  bit pop_r [NI][RING];
  int head [NI];
  int tail [NI];
  int cnt_m [NI];
  bit exp_tx [NI];
  bit exp_busy [NI];
  bit acc_flag [NI];
  int acc_edge [NI];
  int edge_n = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic push_level(input int i, input bit lv);
    for (int r = 0; r < CPB; r++) begin
      lvl_r[i][tail[i] % RING] = lv;
      pop_r[i][tail[i] % RING] = 1'b0;
      tail[i]++;
    end
  endtask

  task automatic append_frame(input int i, input logic [7:0] b);
    int ones;
    int db;
    db = cfg_db(i);
    if (head[i] == tail[i]) begin
      // Line idle: one more idle cycle (the pop) before the start bit.
      lvl_r[i][tail[i] % RING] = 1'b1;
      pop_r[i][tail[i] % RING] = 1'b1;
      tail[i]++;
    end else begin
      pop_r[i][(tail[i] - 1) % RING] = 1'b1;
    end
    push_level(i, 1'b0);
    ones = 0;
    for (int j = 0; j < db; j++) begin
      push_level(i, b[j]);
      if (b[j]) ones++;
    end
    if (cfg_par(i) == 2) push_level(i, (ones % 2) == 1);
    if (cfg_par(i) == 1) push_level(i, (ones % 2) == 0);
    for (int s = 0; s < cfg_sb(i); s++) push_level(i, 1'b1);
  endtask

  // Model update on every rising edge.
  initial begin
    for (int i = 0; i < NI; i++) begin
      head[i] = 0; tail[i] = 0; cnt_m[i] = 0;
      exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; acc_flag[i] = 1'b0; acc_edge[i] = -1;
    end
    forever begin
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < NI; i++) begin
        bit rdy;
        bit consumed;
        acc_flag[i] = 1'b0;
        if (rst === 1'b1) begin
          started  = 1'b1;
          head[i]  = 0;
          tail[i]  = 0;
          cnt_m[i] = 0;
          exp_tx[i]   = 1'b1;
          exp_busy[i] = 1'b0;
        end else begin
          rdy = (cnt_m[i] != DEPTH);
          consumed = (head[i] != tail[i]);
          if (consumed) begin
            exp_tx[i] = lvl_r[i][head[i] % RING];
            if (pop_r[i][head[i] % RING]) cnt_m[i]--;
            head[i]++;
          end else begin
            exp_tx[i] = 1'b1;
          end
          if (valid_v[i] && rdy) begin
            append_frame(i, data_v[i]);
            cnt_m[i]++;
            acc_flag[i] = 1'b1;
            acc_edge[i] = edge_n;
          end
          exp_busy[i] = consumed || (head[i] != tail[i]);
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("i%0d tx", i), 32'(tx_w[i]), 32'(exp_tx[i]));
          chk($sformatf("i%0d busy", i), 32'(busy_w[i]), 32'(exp_busy[i]));
          chk($sformatf("i%0d data_ready", i), 32'(ready_w[i]),
              32'((rst == 1'b0) && (cnt_m[i] != DEPTH)));
          chk($sformatf("i%0d fifo_count", i), 32'(cnt_w[i]), 32'(cnt_m[i]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_edge(input int t);
    int g = 0;
    @(negedge clk);
    while (edge_n < t && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("at_edge", 32'(edge_n), 32'(t));
  endtask

  task automatic send(input int i, input logic [7:0] b, output int e);
    int g = 0;
    step();
    valid_v[i] = 1'b1;
    data_v[i]  = b;
    do begin
      step();
      g++;
    end while (!acc_flag[i] && g < 500);
    valid_v[i] = 1'b0;
    e = acc_edge[i];
    chk($sformatf("send i%0d handshake", i), 32'(acc_flag[i]), 32'd1);
  endtask

  task automatic wait_idle();
    int g = 0;
    bit idle;
    do begin
      step();
      g++;
      idle = 1'b1;
      for (int i = 0; i < NI; i++) if (head[i] != tail[i] || cnt_m[i] != 0) idle = 1'b0;
    end while (!idle && g < 3000);
    chk("wait_idle", 32'(idle), 32'd1);
    repeat (3) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, e3, fe, idx;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      valid_v[i] = 1'b0;
      data_v[i]  = 8'h00;
    end

    // Reset state.
    step();
    step();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset i%0d tx", i), 32'(tx_w[i]), 32'd1);
      chk($sformatf("reset i%0d busy", i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("reset i%0d fifo_count", i), 32'(cnt_w[i]), 32'd0);
      chk($sformatf("reset i%0d data_ready", i), 32'(ready_w[i]), 32'd0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("post-reset i%0d data_ready", i), 32'(ready_w[i]), 32'd1);
    end

    // 8N1 frame of 0x55: latency, bit pattern and busy fall.
    send(0, 8'h55, e);
    at_edge(e);
    chk("t1 count after push", 32'(cnt_w[0]), 32'd1);
    chk("t1 busy after push", 32'(busy_w[0]), 32'd1);
    at_edge(e + 1);
    chk("t1 tx idle at pop", 32'(tx_w[0]), 32'd1);
    chk("t1 count after pop", 32'(cnt_w[0]), 32'd0);
    at_edge(e + 2);  chk("t1 start first", 32'(tx_w[0]), 32'd0);
    at_edge(e + 5);  chk("t1 start last", 32'(tx_w[0]), 32'd0);
    at_edge(e + 6);  chk("t1 bit0", 32'(tx_w[0]), 32'd1);
    at_edge(e + 10); chk("t1 bit1", 32'(tx_w[0]), 32'd0);
    at_edge(e + 38); chk("t1 stop", 32'(tx_w[0]), 32'd1);
    at_edge(e + 41); chk("t1 busy last stop", 32'(busy_w[0]), 32'd1);
    at_edge(e + 42); chk("t1 busy fell", 32'(busy_w[0]), 32'd0);
    wait_idle();

    // Parity: 0x07 gives even parity 1 and odd parity 0; frame 44 cycles.
    send(1, 8'h07, e);
    at_edge(e + 37); chk("t2 even bit7", 32'(tx_w[1]), 32'd0);
    at_edge(e + 38); chk("t2 even parity", 32'(tx_w[1]), 32'd1);
    at_edge(e + 45); chk("t2 even busy end", 32'(busy_w[1]), 32'd1);
    at_edge(e + 46); chk("t2 even busy fell", 32'(busy_w[1]), 32'd0);
    send(2, 8'h07, e);
    at_edge(e + 38); chk("t2 odd parity", 32'(tx_w[2]), 32'd0);
    at_edge(e + 46); chk("t2 odd busy fell", 32'(busy_w[2]), 32'd0);
    send(1, 8'h03, e);
    send(1, 8'hFF, e);
    send(2, 8'h00, e);
    send(2, 8'hA1, e);
    wait_idle();

    // 7N2: seven high data bits, 8 stop cycles, next start immediately after.
    send(3, 8'h7F, e);
    send(3, 8'h00, e2);
    at_edge(e + 33); chk("t4 last data bit", 32'(tx_w[3]), 32'd1);
    at_edge(e + 34); chk("t4 stop first", 32'(tx_w[3]), 32'd1);
    at_edge(e + 41); chk("t4 stop last", 32'(tx_w[3]), 32'd1);
    at_edge(e + 42); chk("t4 next start", 32'(tx_w[3]), 32'd0);
    wait_idle();

    // Streaming 0x41..0x46 with data_valid held: back-pressure and order.
    step();
    valid_v[0] = 1'b1;
    data_v[0]  = 8'h41;
    idx = 0;
    fe = -100;
    for (int g = 0; g < 600 && idx < 6; g++) begin
      step();
      if (acc_flag[0]) begin
        if (idx == 0) fe = edge_n;
        idx++;
        if (idx < 6) data_v[0] = 8'(8'h41 + idx);
        else valid_v[0] = 1'b0;
      end
      if (edge_n == fe + 3) begin
        chk("t3 ready with 3 queued", 32'(ready_w[0]), 32'd1);
        chk("t3 count 3", 32'(cnt_w[0]), 32'd3);
      end
      if (edge_n == fe + 4) begin
        chk("t3 ready full", 32'(ready_w[0]), 32'd0);
        chk("t3 count 4", 32'(cnt_w[0]), 32'd4);
      end
    end
    valid_v[0] = 1'b0;
    chk("t3 bytes accepted", 32'(idx), 32'd6);
    wait_idle();

    // Push and pop on the same edge with two bytes queued.
    send(0, 8'h11, e);
    send(0, 8'h22, e2);
    send(0, 8'h33, e3);
    while (edge_n < e + 40) step();
    chk("t6 count before", 32'(cnt_w[0]), 32'd2);
    valid_v[0] = 1'b1;
    data_v[0]  = 8'h44;
    step();
    valid_v[0] = 1'b0;
    chk("t6 count after push+pop", 32'(cnt_w[0]), 32'd2);
    chk("t6 next start not yet on pin", 32'(tx_w[0]), 32'd1);
    wait_idle();

    // Reset mid-DATA with two bytes queued.
    send(0, 8'hA5, e);
    send(0, 8'h5A, e2);
    send(0, 8'h3C, e3);
    at_edge(e + 20);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t5 ready during rst", 32'(ready_w[0]), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5 tx after rst", 32'(tx_w[0]), 32'd1);
    chk("t5 busy after rst", 32'(busy_w[0]), 32'd0);
    chk("t5 count after rst", 32'(cnt_w[0]), 32'd0);
    chk("t5 ready after rst", 32'(ready_w[0]), 32'd1);
    repeat (60) @(negedge clk);
    chk("t5 line stays idle", 32'(tx_w[0]), 32'd1);
    chk("t5 stays not busy", 32'(busy_w[0]), 32'd0);
    send(0, 8'hC3, e);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
